// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } dmem_state_t;

  localparam logic [15:0] DMEM_IO_ADDR = 16'hFFFE;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, registered synchronous read.
// Only the read register is reset; the array contents survive reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int n     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [n-1:0]  wdata_i,
  output logic [n-1:0]  rdata_o
);

  logic [n-1:0] mem_q [DEPTH];
  logic [n-1:0] rdata_q;

  // Array write port, no reset so contents persist.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register holds the last word read until the next read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= {n{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: decodes load/store requests, drives the RAM with a
// multi-cycle read latency, stalls the core, and owns one memory-mapped output.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int           n       = 16,
  parameter int           DEPTH   = 256,
  parameter int           RD_LAT  = 2,
  parameter logic [n-1:0] IO_ADDR = DMEM_IO_ADDR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic         stall,
  output logic         err,
  output logic [n-1:0] io_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [n-1:0]  io_q, io_d;
  logic          err_q, err_d;

  logic [AW-1:0] word_s;
  logic [AW-1:0] ram_addr_s;
  logic [n-1:0]  ram_rdata_s;
  logic          access_s, bad_s, io_s;
  logic          ram_we_s, ram_re_s, stall_s, io_rd_s;

  assign word_s   = addr[AW:1];
  assign access_s = memread | memwrite;
  assign bad_s    = (memread & memwrite) | (access_s & addr[0]);
  assign io_s     = (addr == IO_ADDR);

  // Request decode and FSM next-state; requests only matter in IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    io_d       = io_q;
    err_d      = err_q;
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    ram_addr_s = addr_q;
    stall_s    = 1'b0;
    io_rd_s    = 1'b0;
    case (state_q)
      IDLE: begin
        ram_addr_s = word_s;
        if (bad_s) begin
          err_d = 1'b1;
        end else if (memwrite) begin
          if (io_s) begin
            io_d = writedata;
          end else begin
            ram_we_s = 1'b1;
          end
        end else if (memread) begin
          if (io_s) begin
            io_rd_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            addr_d  = word_s;
            // With single-cycle latency the read launches straight from IDLE.
            if (RD_LAT > 1) begin
              state_d = RD_WAIT;
              cnt_d   = CW'(RD_LAT - 2);
            end else begin
              ram_re_s = 1'b1;
              state_d  = RD_DONE;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        stall_s = 1'b1;
        if (cnt_q == {CW{1'b0}}) begin
          ram_re_s = 1'b1;
          state_d  = RD_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, latched word address, IO register and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      addr_q  <= {AW{1'b0}};
      io_q    <= {n{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      io_q    <= io_d;
      err_q   <= err_d;
    end
  end

  dmem_ram #(
    .n     (n),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (ram_we_s & ~reset),
    .re_i    (ram_re_s & ~reset),
    .addr_i  (ram_addr_s),
    .wdata_i (writedata),
    .rdata_o (ram_rdata_s)
  );

  assign readdata = io_rd_s ? io_q : ram_rdata_s;
  assign stall    = stall_s;
  assign err      = err_q;
  assign io_out   = io_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level reference model,
// per-cycle compare on the falling edge, directed pins plus random traffic.
module tb_dmem_ctrl;

  localparam int N      = 16;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;
  localparam logic [15:0] IOA = 16'hFFFE;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [15:0] addr;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        stall;
  logic        err;
  logic [15:0] io_out;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .n       (N),
    .DEPTH   (DEPTH),
    .RD_LAT  (RD_LAT),
    .IO_ADDR (IOA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .err       (err),
    .io_out    (io_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  logic [15:0] io_m;
  logic [15:0] rd_m;
  bit          rd_known_m;
  bit          err_m;

  // Per-cycle expectations
  logic        exp_stall;
  logic [15:0] exp_rd;
  bit          exp_rd_known;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {15'd0, stall}, {15'd0, exp_stall});
      chk("err", {15'd0, err}, {15'd0, err_m});
      chk("io_out", io_out, io_m);
      if (exp_rd_known) chk("readdata", readdata, exp_rd);
    end
  end

  function automatic int widx(input logic [15:0] a);
    return int'(a >> 1) % DEPTH;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_rd();
    exp_rd       = rd_m;
    exp_rd_known = rd_known_m;
  endtask

  task automatic do_idle(output logic [15:0] cap_io, output logic cap_err);
    memread = 1'b0; memwrite = 1'b0; addr = 16'($urandom); writedata = 16'($urandom);
    exp_stall = 1'b0;
    hold_rd();
    @(negedge clk);
    cap_io  = io_out;
    cap_err = err;
    next_cycle();
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    memread = 1'b0; memwrite = 1'b1; addr = a; writedata = d;
    exp_stall = 1'b0;
    hold_rd();
    next_cycle();
    if (a[0]) begin
      err_m = 1'b1;
    end else if (a == IOA) begin
      io_m = d;
    end else begin
      mem_m[widx(a)]   = d;
      known_m[widx(a)] = 1'b1;
    end
  endtask

  task automatic do_bad_both(input logic [15:0] a);
    memread = 1'b1; memwrite = 1'b1; addr = a; writedata = 16'($urandom);
    exp_stall = 1'b0;
    hold_rd();
    next_cycle();
    err_m = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] a, output logic [15:0] cap_rd, output int cap_stalls);
    memread = 1'b1; memwrite = 1'b0; addr = a; writedata = 16'($urandom);
    cap_stalls = 0;
    cap_rd     = 16'h0000;
    if (a[0] || a == IOA) begin
      exp_stall = 1'b0;
      if (a[0]) begin
        hold_rd();
      end else begin
        exp_rd       = io_m;
        exp_rd_known = 1'b1;
      end
      @(negedge clk);
      cap_rd = readdata;
      if (stall) cap_stalls++;
      next_cycle();
      if (a[0]) err_m = 1'b1;
    end else begin
      for (int c = 0; c <= RD_LAT; c++) begin
        if (c < RD_LAT) begin
          exp_stall = 1'b1;
        end else begin
          exp_stall  = 1'b0;
          rd_m       = mem_m[widx(a)];
          rd_known_m = known_m[widx(a)];
        end
        hold_rd();
        @(negedge clk);
        if (stall) cap_stalls++;
        cap_rd = readdata;
        next_cycle();
      end
    end
  endtask

  task automatic model_reset();
    err_m      = 1'b0;
    io_m       = 16'h0000;
    rd_m       = 16'h0000;
    rd_known_m = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rdv, rdv2, capio;
    logic        caperr;
    int          ns, ns2;
    logic [15:0] a, d;

    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = 16'h0000; writedata = 16'h0000;
    model_reset();
    exp_stall = 1'b0;
    hold_rd();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset state
    do_idle(capio, caperr);
    chk("rst_io", capio, 16'h0000);
    chk("rst_err", {15'd0, caperr}, 16'h0000);

    // Store then load through RAM
    do_store(16'h0010, 16'h1234);
    do_load(16'h0010, rdv, ns);
    chk("ld_rd", rdv, 16'h1234);
    chk("ld_stalls", 16'(ns), 16'd2);

    // IO register store and combinational load
    do_store(IOA, 16'hBEEF);
    do_idle(capio, caperr);
    chk("io_store", capio, 16'hBEEF);
    do_load(IOA, rdv, ns);
    chk("io_load", rdv, 16'hBEEF);
    chk("io_load_stalls", 16'(ns), 16'd0);

    // Misaligned store sets sticky err, RAM untouched
    do_store(16'h0011, 16'h9999);
    do_idle(capio, caperr);
    chk("err_set", {15'd0, caperr}, 16'h0001);
    do_load(16'h0010, rdv, ns);
    chk("err_ld_rd", rdv, 16'h1234);
    do_idle(capio, caperr);
    chk("err_sticky", {15'd0, caperr}, 16'h0001);

    // Clear via reset, then read&write together sets err
    chk_en = 1'b0; reset = 1'b1; next_cycle(); reset = 1'b0; model_reset(); chk_en = 1'b1;
    do_bad_both(16'h0010);
    do_idle(capio, caperr);
    chk("both_err", {15'd0, caperr}, 16'h0001);

    // Aliasing modulo 2*DEPTH bytes
    do_store(16'h0200, 16'hA5A5);
    do_load(16'h0000, rdv, ns);
    chk("alias_rd", rdv, 16'hA5A5);

    // Back-to-back loads
    do_store(16'h0020, 16'h1111);
    do_store(16'h0022, 16'h2222);
    do_load(16'h0020, rdv, ns);
    do_load(16'h0022, rdv2, ns2);
    chk("b2b_rd0", rdv, 16'h1111);
    chk("b2b_rd1", rdv2, 16'h2222);
    chk("b2b_stalls", 16'(ns + ns2), 16'd4);

    // Reset during RD_WAIT discards the read
    do_store(IOA, 16'h5A5A);
    memread = 1'b1; memwrite = 1'b0; addr = 16'h0022;
    exp_stall = 1'b1;
    hold_rd();
    @(negedge clk);
    next_cycle();
    chk_en = 1'b0; reset = 1'b1;
    next_cycle();
    reset = 1'b0; memread = 1'b0; model_reset(); chk_en = 1'b1;
    exp_stall = 1'b0;
    hold_rd();
    @(negedge clk);
    chk("rstw_rd", readdata, 16'h0000);
    chk("rstw_stall", {15'd0, stall}, 16'h0000);
    chk("rstw_io", io_out, 16'h0000);
    next_cycle();
    do_load(16'h0020, rdv, ns);
    chk("rstw_mem", rdv, 16'h1111);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      a = 16'($urandom) & 16'hFE1E;
      d = 16'($urandom);
      case ($urandom_range(0, 11))
        0, 1, 2: do_store(a, d);
        3, 4, 5: do_load(a, rdv, ns);
        6:       do_store(IOA, d);
        7:       do_load(IOA, rdv, ns);
        8:       if ($urandom_range(0, 3) == 0) do_store(a | 16'h0001, d);
                 else do_idle(capio, caperr);
        9:       if ($urandom_range(0, 7) == 0) do_bad_both(a);
                 else do_idle(capio, caperr);
        10:      if ($urandom_range(0, 5) == 0) do_load(a | 16'h0001, rdv, ns);
                 else do_load(a, rdv, ns);
        default: do_idle(capio, caperr);
      endcase
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
